tl45_wb_timer: RTL

Wishbone-classic slave peripheral that answers the memory stage's IN/OUT and LW/SW bus cycles in the IO region. It provides a 32-bit free-running timer with compare, auto-reload and a sticky match flag, exposed as four word registers. It sits on the shared data bus beside RAM. It is the responder end of the memory stage's initiator protocol: accept a strobe, then return one ack, or one ack together with err.

---
 rtl/tl45_io_pkg.sv | 35 +++
 rtl/tl45_timer_counter.sv | 40 ++++
 rtl/tl45_wb_timer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tl45_io_pkg.sv
// rtl/tl45_io_pkg.sv - shared IO-region constants, register map and FSM type for tl45 IO slaves
package tl45_io_pkg;

  localparam logic [15:0] IO_PREFIX = 16'h00ff;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_COUNT   = 3'd1;
  localparam logic [2:0] REG_COMPARE = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STATUS_MATCH = 0;

  localparam logic [31:0] COMPARE_RESET = 32'hffffffff;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/tl45_timer_counter.sv
// rtl/tl45_timer_counter.sv - COUNT/COMPARE/MATCH datapath with bus load, W1C and auto-reload
module tl45_timer_counter
  import tl45_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        reload,
  input  logic        count_load,
  input  logic [31:0] count_wdata,
  input  logic        compare_load,
  input  logic [31:0] compare_wdata,
  input  logic        match_clr,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match
);

  logic hit;
  assign hit = en && (count == compare);

  // Bus load wins over reload/increment; a match set wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= COMPARE_RESET;
      match   <= 1'b0;
    end else begin
      if (count_load)        count <= count_wdata;
      else if (hit && reload) count <= '0;
      else if (en)           count <= count + 32'd1;

      if (compare_load) compare <= compare_wdata;

      if (hit)            match <= 1'b1;
      else if (match_clr) match <= 1'b0;
    end
  end

endmodule

// File: rtl/tl45_wb_timer.sv
// rtl/tl45_wb_timer.sv - Wishbone-classic timer slave; o_irq and CTRL.IRQ_EN only with TL45_TIMER_IRQ_EN
module tl45_wb_timer
  import tl45_io_pkg::*;
#(
  parameter logic [13:0] BASE_IDX    = 14'h0010,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
`ifdef TL45_TIMER_IRQ_EN
  output logic        o_irq,
`endif
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic        req_we;
  logic [2:0]  req_off;
  logic [31:0] req_data;
  logic [3:0]  req_sel;

  logic        hit;
  logic        unmapped;
  logic        commit;
  logic        ctrl_en, ctrl_reload, ctrl_irq_en;
  logic [31:0] count_val, compare_val;
  logic        match;

  assign hit = i_wb_cyc && i_wb_stb && (i_wb_addr[29:14] == IO_PREFIX)
               && (i_wb_addr[13:3] == BASE_IDX[13:3]);
  assign unmapped = req_off[2];
  assign commit   = (state == ST_ACK) && req_we && !unmapped;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      req_we   <= 1'b0;
      req_off  <= '0;
      req_data <= '0;
      req_sel  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && hit) begin
        req_we   <= i_wb_we;
        req_off  <= i_wb_addr[2:0];
        req_data <= i_wb_data;
        req_sel  <= i_wb_sel;
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    o_wb_ack   = 1'b0;
    o_wb_err   = 1'b0;
    o_wb_stall = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
      end
      ST_WAIT: begin
        o_wb_stall = 1'b1;
        if (!i_wb_cyc)           state_next = ST_IDLE;
        else if (wait_cnt == '0) state_next = ST_ACK;
      end
      ST_ACK: begin
        o_wb_stall = 1'b1;
        o_wb_ack   = 1'b1;
        o_wb_err   = unmapped;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
    end else if (commit && req_off == REG_CTRL && req_sel[0]) begin
      ctrl_en     <= req_data[CTRL_EN];
      ctrl_reload <= req_data[CTRL_RELOAD];
    end
  end

`ifdef TL45_TIMER_IRQ_EN
  logic irq_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_irq_en <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (commit && req_off == REG_CTRL && req_sel[0]) ctrl_irq_en <= req_data[CTRL_IRQ_EN];
      irq_q <= match && ctrl_irq_en;
    end
  end

  assign o_irq = irq_q;
`else
  assign ctrl_irq_en = 1'b0;
`endif

  tl45_timer_counter u_counter (
    .clk           (i_clk),
    .reset         (i_reset),
    .en            (ctrl_en),
    .reload        (ctrl_reload),
    .count_load    (commit && req_off == REG_COUNT),
    .count_wdata   (apply_sel(count_val, req_data, req_sel)),
    .compare_load  (commit && req_off == REG_COMPARE),
    .compare_wdata (apply_sel(compare_val, req_data, req_sel)),
    .match_clr     (commit && req_off == REG_STATUS && req_sel[0] && req_data[STATUS_MATCH]),
    .count         (count_val),
    .compare       (compare_val),
    .match         (match)
  );

  // Read data is only driven during the ack of a read; COUNT shows its pre-edge value.
  always_comb begin
    o_wb_data = '0;
    if (state == ST_ACK && !req_we) begin
      case (req_off)
        REG_CTRL:    o_wb_data = {29'd0, ctrl_irq_en, ctrl_reload, ctrl_en};
        REG_COUNT:   o_wb_data = count_val;
        REG_COMPARE: o_wb_data = compare_val;
        REG_STATUS:  o_wb_data = {31'd0, match};
        default:     o_wb_data = '0;
      endcase
    end
  end

endmodule
